// File: rtl/loader_pkg.sv
// Shared state encoding and stream-format constants for the program loader.
package loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 16;
    localparam bit HIGH_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HIGH,
        ST_LOW,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Assemble a word from the two bytes in arrival order.
    function automatic logic [WORD_W-1:0] form_word(input logic [BYTE_W-1:0] first,
                                                    input logic [BYTE_W-1:0] second);
        return HIGH_FIRST ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running 8-bit XOR checksum: clear, seed with the count byte, accumulate data bytes.
module loader_checksum
    import loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_seed_en,
    input  logic [BYTE_W-1:0] i_seed,
    input  logic              i_acc_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [BYTE_W-1:0] o_sum
);

    logic [BYTE_W-1:0] r_sum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_seed_en) begin
            r_sum <= i_seed;
        end else if (i_acc_en) begin
            r_sum <= r_sum ^ i_byte;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: count byte, C+1 words high byte first, optional checksum.
// Define PROGRAM_LOADER_CHECKSUM_EN to expect and verify a trailing XOR checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [15:0]           write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    state_t                r_state;
    logic [BYTE_W-1:0]     r_count;
    logic [BYTE_W-1:0]     r_hi;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  w_start_ok;
    logic                  w_last;

    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR);
    assign w_last     = (r_idx == ADDR_WIDTH'(r_count));

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] w_sum;
    logic              w_seed_en;
    logic              w_acc_en;

    assign w_seed_en = byte_valid && (r_state == ST_COUNT);
    assign w_acc_en  = byte_valid && (r_state == ST_HIGH || r_state == ST_LOW);

    loader_checksum u_checksum (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_start_ok),
        .i_seed_en (w_seed_en),
        .i_seed    (byte_in),
        .i_acc_en  (w_acc_en),
        .i_byte    (byte_in),
        .o_sum     (w_sum)
    );
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_hi          <= '0;
            r_idx         <= '0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            case (r_state)
                // Bytes arriving here, including one alongside start, are dropped.
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (w_start_ok) begin
                        r_state <= ST_COUNT;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        error   <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (byte_valid) begin
                        r_count <= byte_in;
                        r_idx   <= '0;
                        if (int'(byte_in) + 1 > DEPTH) begin
                            r_state <= ST_ERROR;
                            busy    <= 1'b0;
                            error   <= 1'b1;
                        end else begin
                            r_state <= ST_HIGH;
                        end
                    end
                end
                ST_HIGH: begin
                    if (byte_valid) begin
                        r_hi    <= byte_in;
                        r_state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (byte_valid) begin
                        write_enable  <= 1'b1;
                        write_address <= r_idx;
                        write_data    <= form_word(r_hi, byte_in);
                        r_idx         <= r_idx + 1'b1;
                        if (w_last) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            r_state <= ST_CHECK;
`else
                            r_state <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_HIGH;
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                // Words already written stay written whatever the verdict.
                ST_CHECK: begin
                    if (byte_valid) begin
                        busy <= 1'b0;
                        if (byte_in == w_sum) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ST_ERROR;
                            error   <= 1'b1;
                        end
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (DEPTH=256 and DEPTH=4 instances).
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;

    logic        we, busy, done, error;
    logic [15:0] waddr, wdata;
    logic        we4, busy4, done4, error4;
    logic [15:0] waddr4, wdata4;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] q_addr[$];
    logic [15:0] q_data[$];
    int          wr4_cnt = 0;
    logic [15:0] wr4_last = 16'h0;

    always #5 clock = ~clock;

    program_loader #(.DEPTH(256), .ADDR_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_in(byte_in),
        .write_enable(we), .write_address(waddr), .write_data(wdata),
        .busy(busy), .done(done), .error(error)
    );

    program_loader #(.DEPTH(4), .ADDR_WIDTH(16)) dut4 (
        .clock(clock), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_in(byte_in),
        .write_enable(we4), .write_address(waddr4), .write_data(wdata4),
        .busy(busy4), .done(done4), .error(error4)
    );

    always @(negedge clock) begin
        if (we) begin
            q_addr.push_back(waddr);
            q_data.push_back(wdata);
        end
        if (we4) begin
            wr4_cnt  = wr4_cnt + 1;
            wr4_last = waddr4;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        wr4_cnt = 0;
    endtask

    // Two-word reference image: (0,1234), (1,ABCD), checksum 41.
    task automatic send_ref(input logic [7:0] csum);
        send(8'h01); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(csum);
    endtask

    task automatic check_ref_writes(input string tag);
        check({tag, "_nwr"}, q_addr.size(), 2);
        if (q_addr.size() == 2) begin
            check({tag, "_a0"}, q_addr[0], 16'h0000);
            check({tag, "_d0"}, q_data[0], 16'h1234);
            check({tag, "_a1"}, q_addr[1], 16'h0001);
            check({tag, "_d1"}, q_data[1], 16'hABCD);
        end
    endtask

    initial begin
        int bad;
        logic [7:0] idx;

        // Reset state
        tick();
        check("rst_we",    we,    0);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_error", error, 0);
        check("rst_addr",  waddr, 0);
        check("rst_data",  wdata, 0);
        reset = 1'b0;
        tick();

        // Good image
        clear_log();
        pulse_start();
        check("good_busy", busy, 1);
        send_ref(8'h41);
        tick();
        check_ref_writes("good");
        check("good_done",  done,  1);
        check("good_error", error, 0);
        check("good_busy0", busy,  0);

        // Bad checksum: words still written
        clear_log();
        pulse_start();
        check("bad_clr_done", done, 0);
        send_ref(8'h00);
        tick();
        check_ref_writes("badck");
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        check("badck_error", error, 1);
        check("badck_done",  done,  0);
`else
        check("badck_error", error, 0);
        check("badck_done",  done,  1);
`endif

        // Count exceeding DEPTH=4
        clear_log();
        pulse_start();
        send(8'h04);
        tick();
        check("ovf_error4", error4, 1);
        check("ovf_busy4",  busy4,  0);
        check("ovf_done4",  done4,  0);
        tick(); tick();
        check("ovf_nowr4",  wr4_cnt, 0);

        // Reset mid-load after the high byte of word 0
        reset = 1'b1; tick(); reset = 1'b0; tick();
        clear_log();
        pulse_start();
        send(8'h01); send(8'h12);
        reset = 1'b1;
        tick();
        check("midrst_we", we, 0);
        reset = 1'b0;
        tick(); tick();
        check("midrst_nowr", q_addr.size(), 0);
        check("midrst_busy", busy, 0);
        pulse_start();
        send_ref(8'h41);
        tick();
        check_ref_writes("afterrst");
        check("afterrst_done", done, 1);

        // Bytes before start, byte with start, second start mid-load
        reset = 1'b1; tick(); reset = 1'b0; tick();
        clear_log();
        send(8'h55); send(8'h66);
        check("prestart_busy", busy, 0);
        start = 1'b1; byte_valid = 1'b1; byte_in = 8'h02;
        tick();
        start = 1'b0; byte_valid = 1'b0;
        check("withstart_busy", busy, 1);
        send(8'h01); send(8'h12);
        pulse_start();
        send(8'h34); send(8'hAB); send(8'hCD); send(8'h41);
        tick();
        check_ref_writes("restart");
        check("restart_done",  done,  1);
        check("restart_error", error, 0);

        // Full 256-word image back-to-back; data bytes XOR to zero so checksum is FF
        clear_log();
        pulse_start();
        send(8'hFF);
        for (int i = 0; i < 256; i++) begin
            idx = 8'(i);
            send(idx);
            send(~idx);
        end
        send(8'hFF);
        tick();
        check("full_nwr", q_addr.size(), 256);
        bad = 0;
        for (int i = 0; i < 256 && i < q_addr.size(); i++) begin
            idx = 8'(i);
            if (q_addr[i] !== 16'(i) || q_data[i] !== {idx, ~idx}) bad++;
        end
        check("full_content", bad, 0);
        check("full_done", done, 1);
        check("full_error4", error4, 1);

        // Exactly DEPTH words on the DEPTH=4 instance: bytes 00..07 XOR to 0, checksum 03
        clear_log();
        pulse_start();
        send(8'h03);
        for (int i = 0; i < 8; i++) send(8'(i));
        send(8'h03);
        tick();
        check("fit4_nwr",   wr4_cnt,  4);
        check("fit4_last",  wr4_last, 3);
        check("fit4_done",  done4,    1);
        check("fit4_error", error4,   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
